// File: rtl/fir_coeff_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fir_coeff_seq_ctrl
// Description : Host-side sequencer for the reconfigurable FIR filter. Buffers
//               one module's worth of coefficients from a valid/ready stream,
//               bursts them into filter RAM, then issues one sample plus one
//               read window per 600 kHz sample strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_coeff_seq_ctrl #(
  parameter int TAPS        = 10,
  parameter int NUM_MODULES = 4,
  parameter int GAP         = 5,
  parameter int DW          = 16
) (
  input  logic          iClk12M,
  input  logic          iRsn,
  input  logic          iEnSample600k,
  input  logic          iLoadReq,
  input  logic          iCoeffValid,
  input  logic [DW-1:0] iCoeffData,
  output logic          oCoeffReady,
  input  logic [2:0]    iSample,
  input  logic [1:0]    iRunSel,
  output logic          oCoeffUpdateFlag,
  output logic [1:0]    oModuleSel,
  output logic [DW-1:0] oWtDtRam,
  output logic          oMemRdFlag,
  output logic [2:0]    oFirIn,
  output logic          oBusy,
  output logic          oLoadDone,
  output logic          oOverrun
);

  // k indexes the buffer during FILL/BURST and counts the read window (0..TAPS)
  localparam int KW = $clog2(TAPS + 1);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int MW = $clog2(NUM_MODULES + 1);

  localparam logic [KW-1:0] K_LAST = KW'(TAPS - 1);
  localparam logic [KW-1:0] K_TAPS = KW'(TAPS);
  localparam logic [GW-1:0] G_LAST = GW'(GAP - 1);
  localparam logic [MW-1:0] M_LAST = MW'(NUM_MODULES - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FILL     = 3'd1;
  localparam logic [2:0] S_PRE      = 3'd2;
  localparam logic [2:0] S_BURST    = 3'd3;
  localparam logic [2:0] S_GAP      = 3'd4;
  localparam logic [2:0] S_RUN_WAIT = 3'd5;
  localparam logic [2:0] S_RUN_RD   = 3'd6;

  logic [2:0]    state, state_nx;
  logic [KW-1:0] k, k_nx;
  logic [MW-1:0] m, m_nx;
  logic [GW-1:0] g, g_nx;
  logic          pending, pending_nx;

  logic [DW-1:0] coeff_buf [TAPS];

  logic          ready_nx;
  logic          flag_nx;
  logic [1:0]    sel_nx;
  logic [DW-1:0] wt_nx;
  logic          rd_nx;
  logic [2:0]    fir_nx;
  logic          busy_nx;
  logic          done_nx;
  logic          ovr_nx;

  // State and counter registers
  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      state   <= S_IDLE;
      k       <= '0;
      m       <= '0;
      g       <= '0;
      pending <= 1'b0;
    end else begin
      state   <= state_nx;
      k       <= k_nx;
      m       <= m_nx;
      g       <= g_nx;
      pending <= pending_nx;
    end
  end

  // Next-state and counter update logic
  always_comb begin
    state_nx   = state;
    k_nx       = k;
    m_nx       = m;
    g_nx       = g;
    pending_nx = pending;
    case (state)
      S_IDLE: begin
        if (iLoadReq) begin
          state_nx = S_FILL;
          k_nx     = '0;
          m_nx     = '0;
        end
      end
      S_FILL: begin
        if (iCoeffValid && oCoeffReady) begin
          if (k == K_LAST) begin
            state_nx = S_PRE;
            k_nx     = '0;
          end else begin
            k_nx = k + 1'b1;
          end
        end
      end
      S_PRE: begin
        state_nx = S_BURST;
        k_nx     = '0;
      end
      S_BURST: begin
        if (k == K_LAST) begin
          state_nx = S_GAP;
          g_nx     = '0;
        end else begin
          k_nx = k + 1'b1;
        end
      end
      S_GAP: begin
        if (g == G_LAST) begin
          m_nx = m + 1'b1;
          k_nx = '0;
          state_nx = (m == M_LAST) ? S_RUN_WAIT : S_FILL;
        end else begin
          g_nx = g + 1'b1;
        end
      end
      S_RUN_WAIT: begin
        // A load request beats a coincident sample strobe
        if (iLoadReq) begin
          state_nx = S_FILL;
          k_nx     = '0;
          m_nx     = '0;
        end else if (iEnSample600k) begin
          state_nx = S_RUN_RD;
          k_nx     = '0;
        end
      end
      S_RUN_RD: begin
        if (k == K_TAPS) begin
          if (pending || iLoadReq) begin
            state_nx   = S_FILL;
            k_nx       = '0;
            m_nx       = '0;
            pending_nx = 1'b0;
          end else begin
            state_nx = S_RUN_WAIT;
          end
        end else begin
          k_nx = k + 1'b1;
          if (iLoadReq) pending_nx = 1'b1;
        end
      end
      default: begin
        state_nx   = S_IDLE;
        k_nx       = '0;
        m_nx       = '0;
        pending_nx = 1'b0;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state
  always_comb begin
    ready_nx = (state_nx == S_FILL);
    flag_nx  = (state_nx == S_PRE) || (state_nx == S_BURST);
    sel_nx   = oModuleSel;
    if ((state_nx == S_PRE) || (state_nx == S_BURST) || (state_nx == S_GAP))
      sel_nx = 2'(m_nx);
    else if ((state == S_RUN_WAIT) && (state_nx == S_RUN_RD))
      sel_nx = iRunSel;
    wt_nx    = (state_nx == S_BURST) ? coeff_buf[k_nx] : '0;
    rd_nx    = (state_nx == S_RUN_RD);
    fir_nx   = ((state == S_RUN_WAIT) && (state_nx == S_RUN_RD)) ? iSample : 3'd0;
    busy_nx  = (state_nx == S_FILL) || (state_nx == S_PRE) ||
               (state_nx == S_BURST) || (state_nx == S_GAP);
    done_nx  = (state == S_GAP) && (state_nx == S_RUN_WAIT);
    ovr_nx   = oOverrun || ((state == S_RUN_RD) && iEnSample600k);
  end

  // Output registers
  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      oCoeffReady      <= 1'b0;
      oCoeffUpdateFlag <= 1'b0;
      oModuleSel       <= 2'd0;
      oWtDtRam         <= '0;
      oMemRdFlag       <= 1'b0;
      oFirIn           <= 3'd0;
      oBusy            <= 1'b0;
      oLoadDone        <= 1'b0;
      oOverrun         <= 1'b0;
    end else begin
      oCoeffReady      <= ready_nx;
      oCoeffUpdateFlag <= flag_nx;
      oModuleSel       <= sel_nx;
      oWtDtRam         <= wt_nx;
      oMemRdFlag       <= rd_nx;
      oFirIn           <= fir_nx;
      oBusy            <= busy_nx;
      oLoadDone        <= done_nx;
      oOverrun         <= ovr_nx;
    end
  end

  // Coefficient buffer; contents need no reset
  always_ff @(posedge iClk12M) begin
    if ((state == S_FILL) && iCoeffValid && oCoeffReady)
      coeff_buf[k] <= iCoeffData;
  end

endmodule
`default_nettype wire

// File: doc/fir_coeff_seq_ctrl.md
Name: fir_coeff_seq_ctrl

Overview:
Host-side sequencer that drives the control interface of the reconfigurable FIR filter (ReConf_FirFilter), replacing hand-timed stimulus. It accepts coefficients over a valid/ready stream and buffers one module's worth at a time. It then bursts each module's coefficients into the filter RAM using the CoeffUpdateFlag/ModuleSel/WtDtRam protocol. After loading, it issues one sample plus one MemRdFlag read window per 600 kHz sample enable.

Parameters:
TAPS, 10, coefficients per module, and also the read-window length minus one
NUM_MODULES, 4, number of filter modules loaded in sequence (ModuleSel 0..NUM_MODULES-1)
GAP, 5, idle cycles after each coefficient burst
DW, 16, coefficient width

Ports:
iClk12M  in  1  12 MHz system clock
iRsn  in  1  asynchronous active-low reset
iEnSample600k  in  1  one-cycle sample strobe, one every 20 clocks
iLoadReq  in  1  one-cycle request to (re)load all coefficients
iCoeffValid  in  1  coefficient stream valid
iCoeffData  in  DW  coefficient stream data
oCoeffReady  out  1  coefficient stream ready
iSample  in  3  filter input sample, latched on the sample strobe
iRunSel  in  2  module select for read windows, latched on the sample strobe
oCoeffUpdateFlag  out  1  to filter iCoeffUpdateFlag
oModuleSel  out  2  to filter iModuleSel
oWtDtRam  out  DW  to filter iWtDtRam
oMemRdFlag  out  1  to filter iMemRdFlag
oFirIn  out  3  to filter iFirIn
oBusy  out  1  high while a load is in progress (FILL through GAP)
oLoadDone  out  1  one-cycle pulse when all modules are loaded
oOverrun  out  1  sticky flag: sample strobe arrived during a read window

Behaviour:
- Clock and reset: single clock iClk12M. Reset is asynchronous, active-low (iRsn).
- Registered outputs: all outputs are registered.
- Reset values: every output is 0. State is IDLE, module counter m is 0, word counter k is 0, any pending load is cleared. Buffer contents are don't-care.
- State machine: IDLE, FILL, PRE, BURST, GAP, RUN_WAIT, RUN_RD.
- IDLE: iLoadReq=1 sampled -> FILL with m=0.
- FILL:
  - oCoeffReady=1 while k<TAPS.
  - Each valid&ready handshake stores iCoeffData into buf[k], then k++.
  - After the TAPS-th handshake: oCoeffReady=0 on the next cycle, go to PRE.
  - Stalls on iCoeffValid are unbounded. No filter-side output changes during FILL.
- PRE (1 cycle): oCoeffUpdateFlag=1, oModuleSel=m, oWtDtRam=0.
- BURST (exactly TAPS cycles): oCoeffUpdateFlag=1, oModuleSel=m, oWtDtRam=buf[0..TAPS-1] in order, one word per cycle, with no gaps.
- GAP (GAP cycles): oCoeffUpdateFlag=0, oWtDtRam=0, oModuleSel holds m.
  - Then m++. If m==NUM_MODULES: oLoadDone pulses and state goes to RUN_WAIT.
  - Otherwise state goes to FILL with k=0.
- oBusy: 1 in FILL, PRE, BURST and GAP; 0 otherwise.
- RUN_WAIT: on the edge that samples iEnSample600k=1, go to RUN_RD.
  - oMemRdFlag=1.
  - oFirIn=iSample for that first cycle only, then 0.
  - oModuleSel=iRunSel, held for the whole window.
- RUN_RD: oMemRdFlag stays 1 for exactly TAPS+1 cycles total, then 0, and state returns to RUN_WAIT.
  - Window plus idle tail fits within 20 clocks at the defaults.
- iEnSample600k during RUN_RD (including its first cycle): ignored. oOverrun is set and stays set until reset.
- iLoadReq during RUN_WAIT: go to FILL, m=0.
- iLoadReq during RUN_RD: latched as pending and serviced when the window ends, so FILL is entered instead of RUN_WAIT.
- iLoadReq during FILL through GAP: ignored.
- Sample strobes while not in RUN: ignored, do not set oOverrun.
- Simultaneous iLoadReq and iEnSample600k in RUN_WAIT: the load wins and the strobe is dropped.
- Reset mid-burst: outputs clear immediately (asynchronously). A new load restarts at module 0.
- Width rules: oModuleSel is m[1:0]. Counters are sized for TAPS, GAP and NUM_MODULES with no wrap within range.

Test Plan:
- Reset held low mid-BURST -> all outputs become 0 immediately, state returns to IDLE. A fresh load after release starts with oModuleSel=0.
- iLoadReq, then 40 words 0x0A00–0x0A09, 0x0B00–0x0B09, 0x0C00–0x0C09, 0x0D00–0x0D09 streamed back-to-back -> four bursts, each with 1 PRE cycle plus 10 data cycles under oCoeffUpdateFlag=1.
  - oModuleSel is 0, 1, 2, 3 in turn; oWtDtRam carries 0x0A00..0x0D09 in order.
  - Each burst is followed by 5 idle cycles. oLoadDone pulses once.
- Same load with iCoeffValid deasserted for 7 cycles after word 4 -> burst timing and contents are identical to the previous case. The flag never rises until all 10 words of that module are buffered.
- After loading, iSample=3'b001 and iRunSel=2'b01 on a strobe -> oFirIn=001 for 1 cycle, oMemRdFlag high for 11 cycles, oModuleSel=01 for the window. Next window starts exactly 20 clocks later.
- Extra strobe injected 5 cycles into a read window -> window length stays 11 cycles and oOverrun=1 stays set.
- iLoadReq during a read window -> window completes, then FILL is entered (oCoeffReady=1 the next cycle). The next strobe produces no read.
